// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and timing constants for the sprite row fetcher
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int SPRITE_H = 16;

  typedef enum logic [1:0] {IDLE, RD0, RD1, CAP} fetch_state_t;

  typedef logic [1:0] pix_idx_t;

endpackage

// File: rtl/sprite_row_fetcher.sv
// rtl/sprite_row_fetcher.sv - fetches next line's sprite bitplanes in hblank, shifts colour indices out in active video
module sprite_row_fetcher #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 5,
  parameter int SPRITE_H  = sprite_pkg::SPRITE_H,
  parameter int H_ACTIVE  = sprite_pkg::H_ACTIVE,
  parameter int V_TOTAL   = sprite_pkg::V_TOTAL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic                 sprite_en,
  input  logic [10:0]          sprite_x,
  input  logic [9:0]           sprite_y,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [1:0]           pix_idx,
  output logic                 pix_valid,
  output logic                 busy
);
  import sprite_pkg::*;

  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int COL_W = $clog2(WORD_SIZE);

  fetch_state_t         state;
  logic [WORD_SIZE-1:0] plane0_q;
  logic [WORD_SIZE-1:0] plane1_q;
  logic                 row_hit;
  logic                 hit_pending;
  logic [10:0]          x_q;

  logic [9:0]           next_line;
  logic [10:0]          diff;
  logic                 hit;
  logic [ROW_W-1:0]     row;

  // The row is chosen for the line after the current one, since the fetch happens in hblank.
  assign next_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
  assign diff      = {1'b0, next_line} - {1'b0, sprite_y};
  assign hit       = sprite_en && !diff[10] && (diff < 11'(SPRITE_H));
  assign row       = diff[ROW_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_addr    <= '0;
      busy        <= 1'b0;
      x_q         <= '0;
      hit_pending <= 1'b0;
      row_hit     <= 1'b0;
      plane0_q    <= '0;
      plane1_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hcount == 11'(H_ACTIVE)) begin
            x_q         <= sprite_x;
            hit_pending <= hit;
            mem_addr    <= ADDR_BITS'({row, 1'b0});
            busy        <= 1'b1;
            state       <= RD0;
          end
        end
        RD0: begin
          mem_addr <= {mem_addr[ADDR_BITS-1:1], 1'b1};
          state    <= RD1;
        end
        RD1: begin
          plane0_q <= mem_data;
          state    <= CAP;
        end
        CAP: begin
          plane1_q <= mem_data;
          row_hit  <= hit_pending;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [11:0]      h_ext;
  logic [11:0]      x_ext;
  logic             in_span;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] bit_idx;
  pix_idx_t         idx;

  // 12-bit compare keeps a sprite near column 2047 from wrapping onto column 0.
  assign h_ext   = {1'b0, hcount};
  assign x_ext   = {1'b0, x_q};
  assign in_span = row_hit && (hcount < 11'(H_ACTIVE)) &&
                   (h_ext >= x_ext) && (h_ext < x_ext + 12'(WORD_SIZE));
  assign col     = COL_W'(hcount - x_q);
  assign bit_idx = COL_W'(WORD_SIZE - 1) - col;
  assign idx     = in_span ? {plane1_q[bit_idx], plane0_q[bit_idx]} : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_idx   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_idx   <= idx;
      pix_valid <= (idx != 2'b00);
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// tb/tb_sprite_row_fetcher.sv - directed and randomized scan-line bench with a per-pixel reference model
module tb_sprite_row_fetcher;

  localparam int H_TOT = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        sprite_en;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  pix_idx;
  logic        pix_valid;
  logic        busy;

  logic [15:0] ram [0:31];

  int checks = 0;
  int errors = 0;

  bit          m_hit;
  int          m_x;
  int          m_row;
  logic [15:0] m_p0;
  logic [15:0] m_p1;

  sprite_row_fetcher dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .pix_idx(pix_idx), .pix_valid(pix_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sprite RAM: synchronous read, one cycle latency.
  always @(posedge clk) mem_data <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
  endtask

  task automatic model_trigger();
    int nl, d;
    nl    = (int'(vcount) == 524) ? 0 : int'(vcount) + 1;
    d     = nl - int'(sprite_y);
    m_hit = sprite_en && d >= 0 && d < 16;
    m_row = d & 15;
    m_x   = int'(sprite_x);
    m_p0  = ram[2 * m_row];
    m_p1  = ram[2 * m_row + 1];
  endtask

  function automatic logic [1:0] exp_idx(input int h);
    int b;
    if (m_hit && h < 640 && h >= m_x && h < m_x + 16) begin
      b = 15 - (h - m_x);
      return {m_p1[b], m_p0[b]};
    end
    return 2'b00;
  endfunction

  task automatic run_line(input int v, input int h0, input int h1, input int chg_h, input int chg_x);
    logic [1:0] e;
    for (int h = h0; h <= h1; h++) begin
      if (h == chg_h) sprite_x = 11'(chg_x);
      hcount = 11'(h);
      vcount = 10'(v);
      if (h == 640) model_trigger();
      @(posedge clk);
      #1;
      e = exp_idx(h);
      check($sformatf("pix_idx v%0d h%0d", v, h), pix_idx, e);
      check($sformatf("pix_valid v%0d h%0d", v, h), pix_valid, e != 2'b00);
      if (h >= 640 && h <= 643) begin
        check($sformatf("busy v%0d h%0d", v, h), busy, h != 643);
        check($sformatf("mem_addr v%0d h%0d", v, h), mem_addr,
              (h == 640) ? 2 * m_row : 2 * m_row + 1);
      end
    end
  endtask

  initial begin
    int v, nl;
    for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
    reset = 1'b1; hcount = '0; vcount = '0;
    sprite_en = 1'b0; sprite_x = '0; sprite_y = '0;
    m_hit = 0; m_x = 0; m_row = 0; m_p0 = '0; m_p1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_addr", mem_addr, 0);
    check("reset pix_idx", pix_idx, 0);
    check("reset pix_valid", pix_valid, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;

    // Known row pattern: edge pixels colour 3, interior colour 2.
    fill_ram();
    ram[6] = 16'h8001;
    ram[7] = 16'hFFFF;
    sprite_en = 1'b1; sprite_y = 10'd100; sprite_x = 11'd200;
    run_line(102, 0, H_TOT - 1, -1, 0);
    run_line(103, 0, H_TOT - 1, -1, 0);

    sprite_en = 1'b0;
    run_line(103, 0, H_TOT - 1, -1, 0);
    run_line(104, 0, H_TOT - 1, -1, 0);
    sprite_en = 1'b1;

    // Frame wrap: last line fetches row 0 for line 0.
    fill_ram();
    sprite_y = 10'd0; sprite_x = 11'd200;
    run_line(524, 0, H_TOT - 1, -1, 0);
    sprite_x = 11'd630;
    run_line(0, 0, H_TOT - 1, -1, 0);
    sprite_x = 11'd2040;
    run_line(1, 0, H_TOT - 1, -1, 0);
    sprite_x = 11'd200;
    run_line(2, 0, H_TOT - 1, -1, 0);

    // Mid-line position change must wait for the next fetch.
    run_line(10, 0, H_TOT - 1, -1, 0);
    run_line(11, 0, H_TOT - 1, 250, 300);
    run_line(12, 0, H_TOT - 1, -1, 0);

    // Reset while the second plane read is outstanding.
    fill_ram();
    sprite_y = 10'd50; sprite_x = 11'd100;
    run_line(50, 0, H_TOT - 1, -1, 0);
    run_line(51, 0, 641, -1, 0);
    reset = 1'b1;
    #1;
    check("midfetch reset busy", busy, 0);
    check("midfetch reset pix_valid", pix_valid, 0);
    check("midfetch reset pix_idx", pix_idx, 0);
    check("midfetch reset mem_addr", mem_addr, 0);
    m_hit = 0;
    hcount = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_line(52, 0, H_TOT - 1, -1, 0);
    run_line(53, 0, H_TOT - 1, -1, 0);

    for (int n = 0; n < 25; n++) begin
      fill_ram();
      v  = $urandom_range(0, 524);
      nl = (v == 524) ? 0 : v + 1;
      sprite_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) sprite_y = 10'($urandom);
      else sprite_y = 10'((nl - int'($urandom_range(0, 20)) + 1024) % 1024);
      if ($urandom_range(0, 3) == 0) sprite_x = 11'($urandom);
      else sprite_x = 11'($urandom_range(0, 660));
      run_line(v, 0, H_TOT - 1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_fetcher.md
Name: sprite_row_fetcher

Overview:
- Downstream consumer of the sprite bitmap RAM (single-port, synchronous read, 1-cycle read latency).
- During each horizontal blank, fetches the two bitplane words for the sprite row that appears on the next scan line into row registers.
- During the active region, shifts out a 2-bit colour index per pixel to the VGA compositor.
- Owns the RAM's read port; the RAM's write side is driven by the software loader, never by this block.

Parameters:
- WORD_SIZE, 16, bits per RAM word = sprite width in pixels
- ADDR_BITS, 5, RAM address width; the RAM holds 2*SPRITE_H words
- SPRITE_H, 16, sprite height in rows
- H_ACTIVE, 640, visible pixels per line; a fetch is triggered at hcount == H_ACTIVE
- V_TOTAL, 525, lines per frame, including blanking

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  11  current horizontal pixel counter
- vcount  in  10  current line counter
- sprite_en  in  1  sprite visible this frame
- sprite_x  in  11  sprite left column
- sprite_y  in  10  sprite top line
- mem_addr  out  ADDR_BITS  RAM read address
- mem_data  in  WORD_SIZE  RAM read data, valid the cycle after mem_addr is presented
- pix_idx  out  2  colour index {plane1, plane0}
- pix_valid  out  1  sprite pixel is opaque at this position
- busy  out  1  fetch in progress

Behaviour:
- Reset values:
  - mem_addr=0, pix_idx=0, pix_valid=0, busy=0.
  - Row registers plane0_q/plane1_q=0, row_hit=0, x_q=0.
  - FSM=IDLE.
- Line arithmetic:
  - next_line = (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - diff = {1'b0,next_line} - {1'b0,sprite_y}, computed at 11 bits.
  - hit = sprite_en && diff[10]==0 && diff < SPRITE_H.
  - row = diff[3:0].
- Word layout:
  - Word 2*row is plane0; word 2*row+1 is plane1.
  - Bit WORD_SIZE-1 is the leftmost pixel.
- FSM:
  - IDLE: on hcount == H_ACTIVE:
    - Latch x_q=sprite_x and hit_pending=hit.
    - Drive mem_addr=2*row, set busy=1, go to RD0.
    - The fetch runs even when hit=0; plane data is then ignored.
  - RD0: mem_addr=2*row+1 → RD1.
  - RD1: plane0_q <= mem_data → CAP.
  - CAP: plane1_q <= mem_data, row_hit <= hit_pending, busy=0 → IDLE.
  - Fetch latency: 3 cycles after the trigger.
  - Row registers and row_hit hold until the next fetch.
- Pixel output, registered with 1-cycle latency from hcount:
  - in_span = row_hit && hcount < H_ACTIVE && {1'b0,hcount} >= x_q && {1'b0,hcount} < x_q + WORD_SIZE. Compare at 12 bits so x_q near 2047 does not wrap.
  - col = hcount - x_q; bit index = WORD_SIZE-1-col.
  - pix_idx = in_span ? {plane1_q[b], plane0_q[b]} : 0.
  - pix_valid = in_span && pix_idx != 0. Index 0 is transparent.
- Boundaries:
  - Sprite rows below V_TOTAL or columns at or beyond H_ACTIVE are clipped, never wrapped.
  - sprite_y > vcount range ⇒ no hit.
  - Changes to sprite_x/y/en mid-line take effect only at the next fetch, so there is no tearing within a line.
  - If a second trigger arrives while busy (cannot happen with legal timing), it is ignored.
- Reset mid-fetch returns the block to reset values immediately; the next trigger restarts a clean fetch.

Decomposition:
- Package sprite_pkg holds:
  - typedef fetch_state_t {IDLE, RD0, RD1, CAP}.
  - H_ACTIVE, V_TOTAL, SPRITE_H constants.
  - typedef pix_idx_t logic[1:0].
- No sub-module is needed: the FSM and output pipeline live in one module.
- The bench instantiates the existing RAM alongside this block.

Test Plan:
- Preload RAM word 2*3=16'h8001, word 7=16'hFFFF; sprite_y=100, sprite_x=200, vcount=102, trigger at hcount=640:
  - Expect mem_addr 6, then 7.
  - Expect busy high for 3 cycles.
  - On line 103: pix_idx=3 at hcount 200 and 215; pix_idx=2 at hcount 201..214.
  - pix_valid high for hcount 200..215.
- sprite_en=0 → pix_valid never asserts on any line; fetches still occur.
- vcount=V_TOTAL-1, sprite_y=0 → next_line=0; row 0 fetched (addresses 0, 1).
- sprite_x=630 → pixels 630..639 are drawn; nothing appears at hcount ≥ 640 or at wrapped column 0..5.
- Change sprite_x from 200 to 300 at hcount=250 of the active line → the current line still draws at 200; the next line draws at 300.
- Assert reset during RD1 → busy=0, pix_valid=0, row_hit=0; the next trigger completes a normal 3-cycle fetch.
